// File: rtl/neuron_accum_fa.sv
// Integrate-and-fire membrane accumulator: signed integrate, periodic leak, threshold fire, refractory hold.
// Optional clamping of the WIDTH+1-bit update result is enabled by defining NEURON_ACCUM_SAT_EN.
module neuron_accum_fa #(
    parameter int WIDTH       = 16,
    parameter int W_W         = 8,
    parameter int THRESH      = 1000,
    parameter int V_RESET     = 0,
    parameter int LEAK_SHIFT  = 4,
    parameter int LEAK_PERIOD = 16,
    parameter int REFRAC      = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W_W-1:0]   in_w,
    output logic             spike,
    output logic [WIDTH-1:0] vmem,
    output logic [7:0]       spike_cnt,
    output logic             refrac_act
);

    localparam int LCW = (LEAK_PERIOD > 1) ? $clog2(LEAK_PERIOD) : 1;
    localparam int RCW = (REFRAC > 1) ? $clog2(REFRAC) : 1;

    localparam logic [LCW-1:0]          LEAK_LAST   = LCW'(LEAK_PERIOD - 1);
    localparam logic [RCW-1:0]          REFRAC_LOAD = RCW'(REFRAC - 1);
    localparam logic signed [WIDTH-1:0] THRESH_V    = WIDTH'(THRESH);
    localparam logic signed [WIDTH-1:0] VRESET_V    = WIDTH'(V_RESET);

    localparam logic [0:0] S_INTEG  = 1'b0;
    localparam logic [0:0] S_REFRAC = 1'b1;

    logic [0:0]              state;
    logic [LCW-1:0]          leak_cnt;
    logic [RCW-1:0]          refrac_cnt;
    logic signed [WIDTH-1:0] vmem_q;

    logic                    tick;
    logic                    accept;
    logic                    fire;
    logic signed [WIDTH:0]   v_ext;
    logic signed [WIDTH:0]   leak_amt;
    logic signed [WIDTH:0]   l_ext;
    logic signed [WIDTH:0]   w_ext;
    logic signed [WIDTH:0]   s_ext;
    logic signed [WIDTH-1:0] s_nar;

    // Handshake decodes only from registered state; reset holds ready low.
    assign in_ready   = (state == S_INTEG) && !rst;
    assign refrac_act = (state == S_REFRAC);
    assign accept     = in_valid && in_ready;
    assign tick       = (leak_cnt == LEAK_LAST);
    assign vmem       = vmem_q;

    // Leak is taken before the weight so a coincident accept adds onto the leaked value.
    always_comb begin
        v_ext    = {vmem_q[WIDTH-1], vmem_q};
        leak_amt = v_ext >>> LEAK_SHIFT;
        l_ext    = tick ? (v_ext - leak_amt) : v_ext;
        w_ext    = {{(WIDTH + 1 - W_W){in_w[W_W-1]}}, in_w};
        s_ext    = accept ? (l_ext + w_ext) : l_ext;
    end

`ifdef NEURON_ACCUM_SAT_EN
    localparam logic signed [WIDTH:0] MAX_EXT = {2'b00, {(WIDTH - 1){1'b1}}};
    localparam logic signed [WIDTH:0] MIN_EXT = {2'b11, {(WIDTH - 1){1'b0}}};

    always_comb begin
        s_nar = WIDTH'(s_ext);
        if (s_ext > MAX_EXT) begin
            s_nar = WIDTH'(MAX_EXT);
        end else if (s_ext < MIN_EXT) begin
            s_nar = WIDTH'(MIN_EXT);
        end
    end
`else
    // Plain two's-complement wrap; a positive overflow may jump past the threshold.
    always_comb begin
        s_nar = WIDTH'(s_ext);
    end
`endif

    assign fire = (state == S_INTEG) && (s_nar >= THRESH_V);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            leak_cnt <= '0;
        end else if (tick) begin
            leak_cnt <= '0;
        end else begin
            leak_cnt <= leak_cnt + LCW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_INTEG;
            refrac_cnt <= '0;
        end else begin
            case (state)
                S_INTEG: begin
                    if (fire) begin
                        state      <= S_REFRAC;
                        refrac_cnt <= REFRAC_LOAD;
                    end
                end
                default: begin
                    if (refrac_cnt == '0) begin
                        state <= S_INTEG;
                    end else begin
                        refrac_cnt <= refrac_cnt - RCW'(1);
                    end
                end
            endcase
        end
    end

    // During refractory the membrane is pinned, so leak ticks there are simply lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vmem_q    <= VRESET_V;
            spike     <= 1'b0;
            spike_cnt <= 8'd0;
        end else if (state == S_INTEG) begin
            if (fire) begin
                vmem_q    <= VRESET_V;
                spike     <= 1'b1;
                spike_cnt <= spike_cnt + 8'd1;
            end else begin
                vmem_q <= s_nar;
                spike  <= 1'b0;
            end
        end else begin
            vmem_q <= VRESET_V;
            spike  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_neuron_accum_fa.sv
// Directed bench for neuron_accum_fa: default instance plus an 8-bit instance for overflow handling.
// Saturation expectations follow NEURON_ACCUM_SAT_EN as seen by this bench.
module tb_neuron_accum_fa;

    logic               clk;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [7:0]         in_w;
    logic               spike;
    logic signed [15:0] vmem;
    logic [7:0]         spike_cnt;
    logic               refrac_act;

    logic               in_valid8;
    logic               in_ready8;
    logic [7:0]         in_w8;
    logic               spike8;
    logic [7:0]         vmem8;
    logic [7:0]         spike_cnt8;
    logic               refrac_act8;

    int n_cmp;
    int n_fail;
    int edge_n;

    neuron_accum_fa dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_w       (in_w),
        .spike      (spike),
        .vmem       (vmem),
        .spike_cnt  (spike_cnt),
        .refrac_act (refrac_act)
    );

    neuron_accum_fa #(.WIDTH(8), .W_W(8), .THRESH(100)) dut8 (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid8),
        .in_ready   (in_ready8),
        .in_w       (in_w8),
        .spike      (spike8),
        .vmem       (vmem8),
        .spike_cnt  (spike_cnt8),
        .refrac_act (refrac_act8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edges counted since reset release; leak ticks land on multiples of 16.
    always @(posedge clk or posedge rst) begin
        if (rst) edge_n <= 0;
        else     edge_n <= edge_n + 1;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic step_to(input int n);
        int guard;
        guard = 0;
        while (edge_n < n && guard < 200) begin
            step;
            guard++;
        end
        n_cmp++;
        if (edge_n != n) begin
            n_fail++;
            $display("[TB] FAIL step_to: edge %0d, wanted %0d", edge_n, n);
        end
    endtask

    task automatic apply_reset;
        #3 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset;
        in_valid = 1'b1;
        in_w     = 8'd50;
        step;
        in_valid = 1'b0;
        n_cmp++;
        if (vmem !== 16'sd50) begin
            n_fail++;
            $display("[TB] FAIL pre_reset_vmem: got %0d expected 50", vmem);
        end
        #3 rst = 1'b1;
        #1;
        n_cmp++;
        if (vmem !== 16'sd0) begin
            n_fail++;
            $display("[TB] FAIL reset_vmem: got %0d expected 0", vmem);
        end
        n_cmp++;
        if (spike !== 1'b0 || spike_cnt !== 8'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_spike: got spike=%b cnt=%0d expected 0/0", spike, spike_cnt);
        end
        n_cmp++;
        if (in_ready !== 1'b0 || refrac_act !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_ready: got ready=%b refrac=%b expected 0/0", in_ready, refrac_act);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL release_ready: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_integrate_fire;
        apply_reset;
        in_valid = 1'b1;
        in_w     = 8'd127;
        for (int i = 1; i <= 7; i++) begin
            step;
            n_cmp++;
            if (vmem !== 16'(127 * i) || spike !== 1'b0 || in_ready !== 1'b1) begin
                n_fail++;
                $display("[TB] FAIL integ_step%0d: got vmem=%0d spike=%b ready=%b expected %0d/0/1",
                         i, vmem, spike, in_ready, 127 * i);
            end
        end
        step;
        n_cmp++;
        if (vmem !== 16'sd0 || spike !== 1'b1 || spike_cnt !== 8'd1) begin
            n_fail++;
            $display("[TB] FAIL fire: got vmem=%0d spike=%b cnt=%0d expected 0/1/1", vmem, spike, spike_cnt);
        end
        n_cmp++;
        if (in_ready !== 1'b0 || refrac_act !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL fire_refrac: got ready=%b refrac=%b expected 0/1", in_ready, refrac_act);
        end
        for (int c = 2; c <= 3; c++) begin
            step;
            n_cmp++;
            if (in_ready !== 1'b0 || spike !== 1'b0 || vmem !== 16'sd0) begin
                n_fail++;
                $display("[TB] FAIL refrac_cycle%0d: got ready=%b spike=%b vmem=%0d expected 0/0/0",
                         c, in_ready, spike, vmem);
            end
        end
        step;
        in_valid = 1'b0;
        n_cmp++;
        if (in_ready !== 1'b1 || refrac_act !== 1'b0 || vmem !== 16'sd0) begin
            n_fail++;
            $display("[TB] FAIL refrac_exit: got ready=%b refrac=%b vmem=%0d expected 1/0/0",
                     in_ready, refrac_act, vmem);
        end
    endtask

    task automatic test_back_to_back;
        step_to(11);
        in_valid = 1'b1;
        in_w     = 8'd127;
        step_to(15);
        n_cmp++;
        if (vmem !== 16'sd508) begin
            n_fail++;
            $display("[TB] FAIL b2b_pre_tick: got %0d expected 508", vmem);
        end
        step;
        n_cmp++;
        if (vmem !== 16'sd604) begin
            n_fail++;
            $display("[TB] FAIL b2b_tick: got %0d expected 604", vmem);
        end
        step_to(19);
        n_cmp++;
        if (vmem !== 16'sd985 || spike !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL b2b_pre_fire: got vmem=%0d spike=%b expected 985/0", vmem, spike);
        end
        step;
        in_valid = 1'b0;
        n_cmp++;
        if (spike !== 1'b1 || spike_cnt !== 8'd2 || vmem !== 16'sd0) begin
            n_fail++;
            $display("[TB] FAIL b2b_fire: got spike=%b cnt=%0d vmem=%0d expected 1/2/0", spike, spike_cnt, vmem);
        end
    endtask

    task automatic test_leak;
        apply_reset;
        in_valid = 1'b1;
        in_w     = 8'd100;
        for (int i = 0; i < 8; i++) step;
        in_valid = 1'b0;
        step_to(15);
        n_cmp++;
        if (vmem !== 16'sd800) begin
            n_fail++;
            $display("[TB] FAIL leak_before: got %0d expected 800", vmem);
        end
        step;
        n_cmp++;
        if (vmem !== 16'sd750) begin
            n_fail++;
            $display("[TB] FAIL leak_800: got %0d expected 750", vmem);
        end
    endtask

    task automatic test_simultaneous;
        apply_reset;
        in_valid = 1'b1;
        in_w     = 8'd80;
        step;
        step;
        in_valid = 1'b0;
        step_to(15);
        n_cmp++;
        if (vmem !== 16'sd160) begin
            n_fail++;
            $display("[TB] FAIL simul_before: got %0d expected 160", vmem);
        end
        in_valid = 1'b1;
        in_w     = 8'd10;
        step;
        in_valid = 1'b0;
        n_cmp++;
        if (vmem !== 16'sd160) begin
            n_fail++;
            $display("[TB] FAIL simul_tick: got %0d expected 160", vmem);
        end
        step_to(32);
        n_cmp++;
        if (vmem !== 16'sd150) begin
            n_fail++;
            $display("[TB] FAIL leak_160: got %0d expected 150", vmem);
        end
    endtask

    task automatic test_saturation;
        logic [7:0] exp8;
`ifdef NEURON_ACCUM_SAT_EN
        exp8 = 8'h80;
`else
        exp8 = 8'h00;
`endif
        apply_reset;
        in_valid8 = 1'b1;
        in_w8     = 8'h80;
        step;
        n_cmp++;
        if (vmem8 !== 8'h80) begin
            n_fail++;
            $display("[TB] FAIL sat_first: got %0d expected -128", $signed(vmem8));
        end
        step;
        in_valid8 = 1'b0;
        n_cmp++;
        if (vmem8 !== exp8) begin
            n_fail++;
            $display("[TB] FAIL sat_second: got %0d expected %0d", $signed(vmem8), $signed(exp8));
        end
    endtask

    task automatic test_reset_midrefrac;
        apply_reset;
        in_valid = 1'b1;
        in_w     = 8'd127;
        for (int i = 0; i < 8; i++) step;
        n_cmp++;
        if (spike !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL mr_fire: got spike=%b expected 1", spike);
        end
        step;
        n_cmp++;
        if (refrac_act !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL mr_in_refrac: got %b expected 1", refrac_act);
        end
        #3 rst = 1'b1;
        #1;
        n_cmp++;
        if (refrac_act !== 1'b0 || spike_cnt !== 8'd0 || vmem !== 16'sd0 || in_ready !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL mr_reset: got refrac=%b cnt=%0d vmem=%0d ready=%b expected 0/0/0/0",
                     refrac_act, spike_cnt, vmem, in_ready);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        in_w = 8'hFB;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL mr_release_ready: got %b expected 1", in_ready);
        end
        step;
        in_valid = 1'b0;
        n_cmp++;
        if (vmem !== -16'sd5) begin
            n_fail++;
            $display("[TB] FAIL mr_first_weight: got %0d expected -5", vmem);
        end
    endtask

    initial begin
        n_cmp     = 0;
        n_fail    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_w      = 8'd0;
        in_valid8 = 1'b0;
        in_w8     = 8'd0;
        @(posedge clk);
        #1 rst = 1'b0;
        test_reset;
        test_integrate_fire;
        test_back_to_back;
        test_leak;
        test_simultaneous;
        test_saturation;
        test_reset_midrefrac;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/neuron_accum_fa.md
# neuron_accum_fa

Parametrised integrate-and-fire membrane accumulator built on the full-adder datapath. It generalises the single-bit adder cell into a WIDTH-bit signed accumulator with saturation, periodic leak, threshold firing, refractory hold and spike counting. It sits between the synaptic weight fetch, which is the upstream valid/ready source, and the spike router, which consumes SPIKE. There is one instance per neuron.

## Interface
- WIDTH, 16: membrane potential width, signed two's complement.
- W_W, 8: synaptic weight width, signed; must satisfy W_W <= WIDTH.
- THRESH, 1000: firing threshold, signed. The neuron fires when the updated potential is >= THRESH.
- V_RESET, 0: post-fire and reset membrane value, signed.
- LEAK_SHIFT, 4: leak amount is VMEM >>> LEAK_SHIFT (arithmetic shift).
- LEAK_PERIOD, 16: cycles between leak ticks; must be >= 2.
- REFRAC, 3: refractory cycles after a fire; must be >= 1.

Ports:
- CLK  in  1  single clock; all state changes on the rising edge.
- RST  in  1  reset, asynchronous and active-high.
- IN_VALID  in  1  weight offered.
- IN_READY  out  1  weight accepted when IN_VALID && IN_READY at a rising edge.
- IN_W  in  W_W  signed synaptic weight.
- SPIKE  out  1  registered one-cycle fire pulse.
- VMEM  out  WIDTH  registered membrane potential.
- SPIKE_CNT  out  8  spike count; wraps from 255 to 0.
- REFRAC_ACT  out  1  high while in REFRAC state.

## Operation
- State machine with two states:
  - INTEG: IN_READY = 1.
  - REFRAC: IN_READY = 0 and REFRAC_ACT = 1.
- IN_READY and REFRAC_ACT decode from the registered state only; no combinational path from IN_VALID.
- Leak counter:
  - Free-running from 0 to LEAK_PERIOD-1, then wraps to 0.
  - It runs in both states.
  - A leak tick is the cycle in which the counter equals LEAK_PERIOD-1.
- Update in INTEG, evaluated every cycle:
  - l = tick ? VMEM - (VMEM >>> LEAK_SHIFT) : VMEM.
  - s = l + sign-extended IN_W if a weight is accepted, otherwise s = l.
  - Arithmetic is carried out in WIDTH+1 bits, then narrowed per Configuration.
- Simultaneous tick and accept: the leak is applied first and the weight is added to the leaked value, in the same cycle.
- Fire: if the narrowed s >= THRESH in INTEG, then at the next edge:
  - VMEM <= V_RESET.
  - SPIKE <= 1.
  - SPIKE_CNT increments.
  - State becomes REFRAC and the refractory counter loads REFRAC-1.
- Otherwise VMEM <= narrowed s and SPIKE <= 0.
- REFRAC:
  - VMEM is held at V_RESET; leak ticks are ignored.
  - The refractory counter decrements each cycle.
  - When the counter is 0, state returns to INTEG at the next edge.
- Reset (asynchronous, takes effect immediately, including mid-refractory):
  - VMEM = V_RESET, SPIKE = 0, SPIKE_CNT = 0.
  - State = INTEG, leak counter = 0, refractory counter = 0.
  - IN_READY = 0 and REFRAC_ACT = 0 while RST is high.
  - IN_READY = 1 in the first cycle after RST falls.

## Timing
- Accept-to-VMEM latency is 1 edge: a weight accepted at edge k is visible on VMEM after edge k.
- Fire latency:
  - SPIKE is high for exactly the one cycle following the edge at which the threshold-crossing weight was accepted.
  - IN_READY is low in that same cycle.
- The refractory window is exactly REFRAC cycles of IN_READY = 0, starting with the SPIKE cycle.
- The leak tick lands on edges LEAK_PERIOD, 2·LEAK_PERIOD, … counted after RST deasserts. Ticks falling inside REFRAC are lost, not deferred.
- IN_W may change freely while IN_READY = 0; it is sampled only on accept.

## Configuration
- NEURON_ACCUM_SAT_EN defined: the WIDTH+1-bit result is clamped to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
- NEURON_ACCUM_SAT_EN undefined: the result is truncated to WIDTH bits and wraps in two's complement. A wrapped positive overflow can skip the threshold; this is accepted behaviour in this mode.

## Test plan
- Reset: pulse RST mid-cycle → VMEM=0, SPIKE=0, SPIKE_CNT=0 and IN_READY=0 immediately; IN_READY=1 in the first cycle after release.
- Integrate and fire (defaults): eight back-to-back IN_W=+127 starting at cycle 1:
  - VMEM steps 127, 254 … 889.
  - The 8th accept gives 1016 → VMEM=0, SPIKE high for 1 cycle, SPIKE_CNT=1.
  - IN_READY=0 for exactly 3 cycles.
- Leak:
  - Accept weights totalling 800, then idle → at the next tick VMEM=750.
  - Accept weights totalling 160 → at the next tick VMEM=150.
- Simultaneous: with VMEM=160, accept IN_W=+10 on the tick cycle → VMEM=160 (160-10+10).
- Saturation (WIDTH=8, W_W=8, THRESH=100): two accepts of -128 from 0 → VMEM=-128 with NEURON_ACCUM_SAT_EN defined, VMEM=0 without it.
- Reset mid-refractory: assert RST in the 2nd REFRAC cycle → state INTEG and SPIKE_CNT=0 immediately; the first weight after release is accepted and added to V_RESET.
